// File: rtl/mv_row_scheduler.sv
// Row/tile issue scheduler for a tiled matrix-vector product: tracks datapath
// latency with a tag pipeline, accumulates row dot products, and buffers them in a credit-guarded FIFO.
module mv_row_scheduler #(
  parameter int unsigned MATRIX_SIZE    = 32,
  parameter int unsigned TILE           = 8,
  parameter int unsigned PARTIAL_SUM_BW = 20,
  parameter int unsigned ACC_BW         = 26,
  parameter int unsigned PIPE_LAT       = 2,
  parameter int unsigned RES_DEPTH      = 4,
  localparam int unsigned NT = MATRIX_SIZE / TILE,
  localparam int unsigned RW = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1,
  localparam int unsigned TW = (NT > 1) ? $clog2(NT) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic                      rd_en,
  output logic [RW-1:0]             rd_row,
  output logic [TW-1:0]             rd_tile,
  input  logic [PARTIAL_SUM_BW-1:0] tree_sum,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ACC_BW-1:0]         out_data,
  output logic [RW-1:0]             out_row
);

  localparam int unsigned CW = $clog2(RES_DEPTH + 1);
  localparam int unsigned PW = (RES_DEPTH > 1) ? $clog2(RES_DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  typedef struct packed {
    logic          v;
    logic          first;
    logic          last;
    logic [RW-1:0] row;
  } tag_t;

  state_t              state;
  logic [RW-1:0]       row_q;
  logic [TW-1:0]       tile_q;
  logic [CW-1:0]       credit;
  tag_t                tags [PIPE_LAT];
  logic [ACC_BW-1:0]   acc;
  logic [ACC_BW-1:0]   fifo_data [RES_DEPTH];
  logic [RW-1:0]       fifo_row  [RES_DEPTH];
  logic [PW-1:0]       wptr;
  logic [PW-1:0]       rptr;
  logic [CW-1:0]       cnt;

  logic                pop;
  logic                push;
  logic                row_start;
  logic [CW-1:0]       credit_nxt;
  logic [CW-1:0]       cnt_nxt;
  logic                last_tile;
  logic                last_row;
  logic                issue;
  logic                pipe_busy;
  logic                drained;
  tag_t                tail;
  logic [ACC_BW-1:0]   ext;
  logic [ACC_BW-1:0]   sum;

  assign pop        = out_valid && out_ready;
  assign row_start  = rd_en && (rd_tile == '0);
  assign credit_nxt = credit + CW'(row_start) - CW'(pop);
  assign tail       = tags[PIPE_LAT-1];
  assign ext        = ACC_BW'($signed(tree_sum));
  assign sum        = tail.first ? ext : acc + ext;
  assign push       = tail.v && tail.last;
  assign cnt_nxt    = cnt + CW'(push) - CW'(pop);
  assign last_tile  = (tile_q == TW'(NT - 1));
  assign last_row   = (row_q == RW'(MATRIX_SIZE - 1));

  // A new row may only begin when its result is guaranteed a FIFO slot.
  assign issue = ((state == S_ISSUE) || ((state == S_IDLE) && start)) &&
                 ((tile_q != '0) || (credit_nxt < CW'(RES_DEPTH)));

  always_comb begin
    pipe_busy = rd_en;
    for (int i = 0; i < PIPE_LAT; i++) pipe_busy = pipe_busy | tags[i].v;
  end

  assign drained  = !pipe_busy && (cnt_nxt == '0);
  assign out_data = fifo_data[rptr];
  assign out_row  = fifo_row[rptr];

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_row    <= '0;
      rd_tile   <= '0;
      row_q     <= '0;
      tile_q    <= '0;
      credit    <= '0;
      acc       <= '0;
      cnt       <= '0;
      wptr      <= '0;
      rptr      <= '0;
      out_valid <= 1'b0;
      for (int i = 0; i < PIPE_LAT; i++) tags[i] <= '0;
      for (int i = 0; i < RES_DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_row[i]  <= '0;
      end
    end else begin
      done  <= 1'b0;
      rd_en <= issue;
      if (issue) begin
        rd_row  <= row_q;
        rd_tile <= tile_q;
        if (last_tile) begin
          tile_q <= '0;
          row_q  <= last_row ? '0 : row_q + RW'(1);
        end else begin
          tile_q <= tile_q + TW'(1);
        end
      end

      case (state)
        S_IDLE: if (start) begin
          state <= (last_tile && last_row) ? S_DRAIN : S_ISSUE;
          busy  <= 1'b1;
        end
        S_ISSUE: if (issue && last_tile && last_row) state <= S_DRAIN;
        S_DRAIN: if (drained) begin
          state <= S_DONE;
          done  <= 1'b1;
        end
        S_DONE: begin
          state <= S_IDLE;
          busy  <= 1'b0;
        end
        default: state <= S_IDLE;
      endcase

      credit <= credit_nxt;

      // Tag pipeline mirrors the datapath so each tree_sum meets its row context.
      tags[0] <= {rd_en, rd_tile == '0, rd_tile == TW'(NT - 1), rd_row};
      for (int i = 1; i < PIPE_LAT; i++) tags[i] <= tags[i-1];

      if (tail.v) acc <= sum;

      if (push) begin
        fifo_data[wptr] <= sum;
        fifo_row[wptr]  <= tail.row;
        wptr <= (wptr == PW'(RES_DEPTH - 1)) ? '0 : wptr + PW'(1);
      end
      if (pop) rptr <= (rptr == PW'(RES_DEPTH - 1)) ? '0 : rptr + PW'(1);
      cnt       <= cnt_nxt;
      out_valid <= (cnt_nxt != '0);
    end
  end

  fifo_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && !pop && (cnt == CW'(RES_DEPTH))));

endmodule

// File: tb/tb_mv_row_scheduler.sv
// Directed bench for mv_row_scheduler: full passes, backpressure, wrap/overflow,
// start-while-busy and mid-pass reset, with a simple tree_sum datapath model.
module tb_mv_row_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        busy;
  logic        done;
  logic        rd_en;
  logic [4:0]  rd_row;
  logic [1:0]  rd_tile;
  logic [19:0] tree_sum;
  logic        out_valid;
  logic        out_ready;
  logic [25:0] out_data;
  logic [4:0]  out_row;

  logic        start2;
  logic        busy2;
  logic        done2;
  logic        rd_en2;
  logic [4:0]  rd_row2;
  logic [1:0]  rd_tile2;
  logic [19:0] tree_sum2;
  logic        out_valid2;
  logic        out_ready2;
  logic [19:0] out_data2;
  logic [4:0]  out_row2;

  int total = 0;
  int bad   = 0;
  int mode  = 0;

  logic [4:0] p_row  [2];
  logic [1:0] p_tile [2];

  always #5 clk = ~clk;

  mv_row_scheduler dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .rd_en(rd_en), .rd_row(rd_row), .rd_tile(rd_tile), .tree_sum(tree_sum),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_row(out_row)
  );

  mv_row_scheduler #(.ACC_BW(20)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .busy(busy2), .done(done2),
    .rd_en(rd_en2), .rd_row(rd_row2), .rd_tile(rd_tile2), .tree_sum(tree_sum2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_data(out_data2), .out_row(out_row2)
  );

  // Datapath model: tree_sum for a request appears two cycles after its rd_en.
  always @(posedge clk) begin
    p_row[0]  <= rd_row;
    p_tile[0] <= rd_tile;
    p_row[1]  <= p_row[0];
    p_tile[1] <= p_tile[0];
  end

  always @* begin
    if (mode == 1) tree_sum = 20'hFFFFF;
    else           tree_sum = 20'(32'(p_row[1]) * 4 + 32'(p_tile[1]));
  end

  assign tree_sum2  = 20'h7FFFF;
  assign out_ready2 = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] exp_val(input int r);
    if (mode == 1) return 32'h03FF_FFFC;
    return 32'(16 * r + 6);
  endfunction

  task automatic run_pass(input string name, input bit poke);
    int rd_cnt   = 0;
    int rd_first = 0;
    int rd_last  = 0;
    int n_res    = 0;
    int n_done   = 0;
    int done_at  = 0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 1; i <= 140; i++) begin
      @(negedge clk);
      start = poke && (i == 20 || i == 130);
      if (rd_en) begin
        rd_cnt++;
        if (rd_first == 0) rd_first = i;
        rd_last = i;
      end
      if (out_valid && out_ready) begin
        chk({name, "_row"}, 32'(out_row), 32'(n_res));
        chk({name, "_data"}, 32'(out_data), exp_val(n_res));
        n_res++;
      end
      if (done) begin
        n_done++;
        done_at = i;
      end
      if (i == 133) chk({name, "_busy_low"}, 32'(busy), 32'd0);
    end
    chk({name, "_rd_cnt"}, 32'(rd_cnt), 32'd128);
    chk({name, "_rd_first"}, 32'(rd_first), 32'd1);
    chk({name, "_rd_last"}, 32'(rd_last), 32'd128);
    chk({name, "_n_res"}, 32'(n_res), 32'd32);
    chk({name, "_n_done"}, 32'(n_done), 32'd1);
    chk({name, "_done_at"}, 32'(done_at), 32'd132);
  endtask

  initial begin
    int  rd_cnt;
    int  rd_last;
    int  n;
    bit  got_done;

    rst       = 1'b1;
    start     = 1'b0;
    start2    = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_en", 32'(rd_en), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_rd_row", 32'(rd_row), 32'd0);
    chk("rst_rd_tile", 32'(rd_tile), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_row", 32'(out_row), 32'd0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    mode = 0;
    run_pass("pass_ramp", 1'b0);
    mode = 1;
    run_pass("pass_neg", 1'b0);
    mode = 0;
    run_pass("pass_poke", 1'b1);

    // Backpressure: four rows fill the credit window, then issue stalls.
    out_ready = 1'b0;
    rd_cnt    = 0;
    rd_last   = 0;
    @(negedge clk);
    start = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      start = 1'b0;
      if (rd_en) begin
        rd_cnt++;
        rd_last = i;
      end
      if (i == 20) begin
        chk("bp_head_row_early", 32'(out_row), 32'd0);
        chk("bp_head_data_early", 32'(out_data), 32'd6);
      end
    end
    chk("bp_rd_cnt", 32'(rd_cnt), 32'd16);
    chk("bp_rd_last", 32'(rd_last), 32'd16);
    chk("bp_valid", 32'(out_valid), 32'd1);
    chk("bp_head_row", 32'(out_row), 32'd0);
    chk("bp_head_data", 32'(out_data), 32'd6);
    out_ready = 1'b1;
    @(negedge clk);
    chk("bp_resume_en", 32'(rd_en), 32'd1);
    chk("bp_resume_row", 32'(rd_row), 32'd4);
    chk("bp_resume_tile", 32'(rd_tile), 32'd0);
    chk("bp_next_row", 32'(out_row), 32'd1);
    chk("bp_next_data", 32'(out_data), 32'd22);
    n        = 1;
    got_done = 1'b0;
    for (int j = 0; j < 400 && !got_done; j++) begin
      if (j > 0) @(negedge clk);
      if (out_valid && out_ready) begin
        chk("bp_row", 32'(out_row), 32'(n));
        chk("bp_data", 32'(out_data), exp_val(n));
        n++;
      end
      if (done) got_done = 1'b1;
    end
    chk("bp_done", 32'(got_done), 32'd1);
    chk("bp_count", 32'(n), 32'd32);
    repeat (3) @(negedge clk);

    // Narrow accumulator: four tiles of 0x7FFFF wrap to 0xFFFFC.
    n        = 0;
    got_done = 1'b0;
    start2   = 1'b1;
    for (int j = 0; j < 200 && !got_done; j++) begin
      @(negedge clk);
      start2 = 1'b0;
      if (out_valid2) begin
        chk("ovf_row", 32'(out_row2), 32'(n));
        chk("ovf_data", 32'(out_data2), 32'h000F_FFFC);
        n++;
      end
      if (done2) got_done = 1'b1;
    end
    chk("ovf_done", 32'(got_done), 32'd1);
    chk("ovf_count", 32'(n), 32'd32);
    repeat (3) @(negedge clk);

    // Reset in the middle of a pass, then a clean pass.
    @(negedge clk);
    start = 1'b1;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_valid", 32'(out_valid), 32'd0);
    chk("midrst_rd_en", 32'(rd_en), 32'd0);
    chk("midrst_credit", 32'(dut.credit), 32'd0);
    run_pass("pass_after_rst", 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
